// File: rtl/lcd_fb_window.sv
// Framebuffer window renderer: pixel coordinates -> framebuffer reads -> composited pixel (picture/border/background).
// Latency: fb_rd_addr/fb_rd_en/frame_done 1 cycle after coordinates, pixel_data RD_LAT+2 cycles after coordinates.
// Backpressure: none; one read per active cycle, the framebuffer must accept back-to-back reads.
//
// Ports: lcd_pclk/rst_n (async active-low); pixel_xpos/pixel_ypos from the timing generator;
// scale_sel/win_en sampled at frame start; fb_rd_en/fb_rd_addr/fb_rd_data to the framebuffer read port;
// pixel_data composited output; frame_done pulses with the final issue of the last picture address.
module lcd_fb_window #(
    parameter logic [10:0]        X_START      = 11'd1,
    parameter logic [10:0]        Y_START      = 11'd1,
    parameter int                 PIC_W        = 400,
    parameter int                 PIC_H        = 300,
    parameter int                 COLOR_W      = 24,
    parameter int                 ADDR_W       = 17,
    parameter int                 RD_LAT       = 1,
    parameter int                 BORDER_W     = 2,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 24'hE0FFFF,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = 24'hFF0000
) (
    input  logic               lcd_pclk,
    input  logic               rst_n,
    input  logic [10:0]        pixel_xpos,
    input  logic [10:0]        pixel_ypos,
    input  logic [1:0]         scale_sel,
    input  logic               win_en,
    output logic               fb_rd_en,
    output logic [ADDR_W-1:0]  fb_rd_addr,
    input  logic [COLOR_W-1:0] fb_rd_data,
    output logic [COLOR_W-1:0] pixel_data,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        CLS_BG  = 2'd0,
        CLS_BRD = 2'd1,
        CLS_PIC = 2'd2
    } cls_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_W * PIC_H - 1);

    logic              frame_start;
    logic [1:0]        sel_sh, sh_eff, sh_q, s_m1;
    logic              en_eff, en_q;
    logic [12:0]       xc, yc, x1, y1;
    logic              in_x, in_y, grow_x, grow_y, new_line;
    cls_t              cls;
    logic [10:0]       ypos_q;
    logic [ADDR_W-1:0] row_base, row_n, col, col_n, addr_n;
    logic [1:0]        sub_y, suby_n, sub_x, subx_n;
    logic              done_n;
    cls_t              cls_pipe [RD_LAT+1];

    assign frame_start = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    assign new_line    = (pixel_ypos != ypos_q);

    // The frame-start pixel itself already uses the newly sampled settings.
    always_comb begin
        sel_sh = 2'd0;
        case (scale_sel)
            2'b01:   sel_sh = 2'd1;
            2'b10:   sel_sh = 2'd2;
            default: sel_sh = 2'd0;
        endcase
        sh_eff = frame_start ? sel_sh : sh_q;
        en_eff = frame_start ? win_en : en_q;
        s_m1   = 2'd0;
        case (sh_eff)
            2'd1:    s_m1 = 2'd1;
            2'd2:    s_m1 = 2'd3;
            default: s_m1 = 2'd0;
        endcase
    end

    // Extents in 13 bits so window + border never wraps; the border test adds
    // BORDER_W on the coordinate side so negative screen positions clip naturally.
    always_comb begin
        xc     = {2'b00, pixel_xpos};
        yc     = {2'b00, pixel_ypos};
        x1     = 13'(X_START) + (13'(PIC_W) << sh_eff);
        y1     = 13'(Y_START) + (13'(PIC_H) << sh_eff);
        in_x   = (xc >= 13'(X_START)) && (xc < x1);
        in_y   = (yc >= 13'(Y_START)) && (yc < y1);
        grow_x = (xc + 13'(BORDER_W) >= 13'(X_START)) && (xc < x1 + 13'(BORDER_W));
        grow_y = (yc + 13'(BORDER_W) >= 13'(Y_START)) && (yc < y1 + 13'(BORDER_W));
        cls    = CLS_BG;
        if (en_eff && in_x && in_y)
            cls = CLS_PIC;
        else if (en_eff && grow_x && grow_y)
            cls = CLS_BRD;
    end

    // Incremental address walk: row_base steps by PIC_W every S lines,
    // col steps by one every S picture cycles.
    always_comb begin
        row_n  = row_base;
        suby_n = sub_y;
        col_n  = col;
        subx_n = sub_x;
        if (frame_start || (yc >= y1)) begin
            row_n  = '0;
            suby_n = 2'd0;
            col_n  = '0;
            subx_n = 2'd0;
        end else begin
            if (new_line && in_y) begin
                if (pixel_ypos == Y_START) begin
                    row_n  = '0;
                    suby_n = 2'd0;
                end else if (sub_y == s_m1) begin
                    row_n  = row_base + ADDR_W'(PIC_W);
                    suby_n = 2'd0;
                end else begin
                    suby_n = sub_y + 2'd1;
                end
            end
            if (in_y && (pixel_xpos == X_START)) begin
                col_n  = '0;
                subx_n = 2'd0;
            end else if (cls == CLS_PIC) begin
                if (sub_x == s_m1) begin
                    col_n  = col + ADDR_W'(1);
                    subx_n = 2'd0;
                end else begin
                    subx_n = sub_x + 2'd1;
                end
            end
        end
        addr_n = row_n + col_n;
        done_n = (cls == CLS_PIC) && (addr_n == LAST_ADDR) &&
                 (subx_n == s_m1) && (suby_n == s_m1);
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= 2'd0;
            en_q       <= 1'b0;
            ypos_q     <= 11'd0;
            row_base   <= '0;
            sub_y      <= 2'd0;
            col        <= '0;
            sub_x      <= 2'd0;
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
            frame_done <= 1'b0;
            pixel_data <= BG_COLOR;
            for (int k = 0; k <= RD_LAT; k++)
                cls_pipe[k] <= CLS_BG;
        end else begin
            sh_q       <= sh_eff;
            en_q       <= en_eff;
            ypos_q     <= pixel_ypos;
            row_base   <= row_n;
            sub_y      <= suby_n;
            col        <= col_n;
            sub_x      <= subx_n;
            fb_rd_en   <= (cls == CLS_PIC);
            frame_done <= done_n;
            if (cls == CLS_PIC)
                fb_rd_addr <= addr_n;
            // Class travels alongside the read so it meets its data.
            cls_pipe[0] <= cls;
            for (int k = 1; k <= RD_LAT; k++)
                cls_pipe[k] <= cls_pipe[k-1];
            case (cls_pipe[RD_LAT])
                CLS_PIC: pixel_data <= fb_rd_data;
                CLS_BRD: pixel_data <= BORDER_COLOR;
                default: pixel_data <= BG_COLOR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fb_window.sv
// Bench for lcd_fb_window: two instances (RD_LAT=1 and RD_LAT=3) share one coordinate raster.
// Latency: expectations due 1 cycle (read port) and RD_LAT+2 cycles (pixel) after the coordinate.
// Backpressure: none; framebuffer models answer every read.
module tb_lcd_fb_window;
    localparam int          PW = 4;
    localparam int          PH = 3;
    localparam int          CW = 24;
    localparam int          AW = 17;
    localparam int          BW = 1;
    localparam logic [10:0] XS = 11'd2;
    localparam logic [10:0] YS = 11'd2;
    localparam logic [CW-1:0] BGC  = 24'hE0FFFF;
    localparam logic [CW-1:0] BRC  = 24'hFF0000;
    localparam logic [CW-1:0] JUNK = 24'h5A5A5A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   px = 11'd0, py = 11'd0;
    logic [1:0]    ss = 2'b00;
    logic          we = 1'b0;
    logic          en1, en3, fd1, fd3;
    logic [AW-1:0] ad1, ad3;
    logic [CW-1:0] pd1, pd3;
    logic [CW-1:0] m1 = '0, m3a = '0, m3b = '0, m3c = '0;

    always #5 clk = ~clk;

    lcd_fb_window #(.X_START(XS), .Y_START(YS), .PIC_W(PW), .PIC_H(PH), .COLOR_W(CW),
                    .ADDR_W(AW), .RD_LAT(1), .BORDER_W(BW), .BG_COLOR(BGC), .BORDER_COLOR(BRC))
    u_lat1 (.lcd_pclk(clk), .rst_n(rst_n), .pixel_xpos(px), .pixel_ypos(py), .scale_sel(ss),
            .win_en(we), .fb_rd_en(en1), .fb_rd_addr(ad1), .fb_rd_data(m1),
            .pixel_data(pd1), .frame_done(fd1));

    lcd_fb_window #(.X_START(XS), .Y_START(YS), .PIC_W(PW), .PIC_H(PH), .COLOR_W(CW),
                    .ADDR_W(AW), .RD_LAT(3), .BORDER_W(BW), .BG_COLOR(BGC), .BORDER_COLOR(BRC))
    u_lat3 (.lcd_pclk(clk), .rst_n(rst_n), .pixel_xpos(px), .pixel_ypos(py), .scale_sel(ss),
            .win_en(we), .fb_rd_en(en3), .fb_rd_addr(ad3), .fb_rd_data(m3c),
            .pixel_data(pd3), .frame_done(fd3));

    // Framebuffer models: data = address, junk when no read is issued.
    always @(posedge clk) begin
        m1  <= en1 ? CW'(ad1) : JUNK;
        m3a <= en3 ? CW'(ad3) : JUNK;
        m3b <= m3a;
        m3c <= m3b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int            stamp;
        int            fid;
        logic          en;
        logic [AW-1:0] addr;
        logic          done;
    } aexp_t;
    typedef struct {
        int            stamp;
        logic [CW-1:0] pix;
    } pexp_t;

    aexp_t qa[$];
    pexp_t qp1[$];
    pexp_t qp3[$];
    aexp_t ea;
    pexp_t ep;

    int            m_sh = 0;
    bit            m_en = 1'b0;
    logic [AW-1:0] last_addr = '0;
    int            fid = 0;
    int            en_cnt[10];
    int            fd_cnt[10];

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].stamp + 1 <= cyc) begin
            ea = qa.pop_front();
            chk("rd_en_l1",   32'(en1), 32'(ea.en));
            chk("rd_en_l3",   32'(en3), 32'(ea.en));
            chk("rd_addr_l1", 32'(ad1), 32'(ea.addr));
            chk("rd_addr_l3", 32'(ad3), 32'(ea.addr));
            chk("frame_done_l1", 32'(fd1), 32'(ea.done));
            chk("frame_done_l3", 32'(fd3), 32'(ea.done));
            if (en1) en_cnt[ea.fid]++;
            if (fd1) fd_cnt[ea.fid]++;
        end
        while (qp1.size() > 0 && qp1[0].stamp + 3 <= cyc) begin
            ep = qp1.pop_front();
            chk("pixel_l1", 32'(pd1), 32'(ep.pix));
        end
        while (qp3.size() > 0 && qp3[0].stamp + 5 <= cyc) begin
            ep = qp3.pop_front();
            chk("pixel_l3", 32'(pd3), 32'(ep.pix));
        end
    end

    task automatic drive(input int x, input int y);
        int s, x0, x1, y0, y1, a;
        bit pic, brd, dn;
        logic [CW-1:0] pix;
        @(posedge clk);
        #1;
        px = 11'(x);
        py = 11'(y);
        if (x == 0 && y == 0) begin
            m_sh = (ss == 2'b01) ? 1 : (ss == 2'b10) ? 2 : 0;
            m_en = we;
        end
        if (rst_n) begin
            s  = 1 << m_sh;
            x0 = int'(XS);
            x1 = x0 + PW * s;
            y0 = int'(YS);
            y1 = y0 + PH * s;
            pic = m_en && x >= x0 && x < x1 && y >= y0 && y < y1;
            brd = m_en && !pic && x >= x0 - BW && x < x1 + BW && y >= y0 - BW && y < y1 + BW;
            a   = pic ? ((y - y0) / s) * PW + (x - x0) / s : 0;
            dn  = pic && a == PW * PH - 1 && (x - x0) % s == s - 1 && (y - y0) % s == s - 1;
            if (pic) last_addr = AW'(a);
            pix = pic ? CW'(a) : (brd ? BRC : BGC);
            qa.push_back('{cyc, fid, pic, last_addr, dn});
            qp1.push_back('{cyc, pix});
            qp3.push_back('{cyc, pix});
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_pix_l1"},  32'(pd1), 32'(BGC));
        chk({pfx, "_pix_l3"},  32'(pd3), 32'(BGC));
        chk({pfx, "_en_l1"},   32'(en1), 32'd0);
        chk({pfx, "_en_l3"},   32'(en3), 32'd0);
        chk({pfx, "_addr_l1"}, 32'(ad1), 32'd0);
        chk({pfx, "_addr_l3"}, 32'(ad3), 32'd0);
        chk({pfx, "_fd_l1"},   32'(fd1), 32'd0);
        chk({pfx, "_fd_l3"},   32'(fd3), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        qa.delete();
        qp1.delete();
        qp3.delete();
        m_sh = 0;
        m_en = 1'b0;
        last_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // 10x8 raster; settings change at line 4; optional blanking gap holds x at 9.
    task automatic frame(input logic [1:0] s0, input logic w0, input logic [1:0] s1,
                         input logic w1, input int gap, input int rst_line);
        fid++;
        ss = s0;
        we = w0;
        for (int y = 0; y < 8; y++) begin
            if (y == 4) begin
                ss = s1;
                we = w1;
            end
            for (int x = 0; x < 10; x++) begin
                drive(x, y);
                if (y == rst_line && x == 3) do_reset();
            end
            for (int g = 0; g < gap; g++) drive(9, y);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;

        frame(2'b00, 1'b1, 2'b00, 1'b1, 0, -1);   // 1: 1x
        frame(2'b01, 1'b1, 2'b01, 1'b1, 0, -1);   // 2: 2x
        frame(2'b00, 1'b1, 2'b10, 1'b1, 0, -1);   // 3: scale change mid-frame, stays 1x
        frame(2'b10, 1'b1, 2'b10, 1'b0, 0, -1);   // 4: 4x (overflows panel), win_en drops mid-frame
        frame(2'b10, 1'b0, 2'b10, 1'b0, 0, -1);   // 5: all background
        frame(2'b00, 1'b1, 2'b00, 1'b1, 20, 3);   // 6: blanking gaps, reset inside window
        frame(2'b00, 1'b1, 2'b00, 1'b1, 20, -1);  // 7: renders again from address 0

        fid = 8;
        we = 1'b0;
        ss = 2'b00;
        for (int i = 0; i < 8; i++) drive(0, 0);
        @(posedge clk);
        @(negedge clk);

        chk("en_cnt_f1", en_cnt[1], 12);
        chk("en_cnt_f2", en_cnt[2], 48);
        chk("en_cnt_f3", en_cnt[3], 12);
        chk("en_cnt_f4", en_cnt[4], 48);
        chk("en_cnt_f5", en_cnt[5], 0);
        chk("en_cnt_f7", en_cnt[7], 12);
        chk("fd_cnt_f1", fd_cnt[1], 1);
        chk("fd_cnt_f2", fd_cnt[2], 1);
        chk("fd_cnt_f3", fd_cnt[3], 1);
        chk("fd_cnt_f4", fd_cnt[4], 0);
        chk("fd_cnt_f5", fd_cnt[5], 0);
        chk("fd_cnt_f7", fd_cnt[7], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_fb_window.md
# lcd_fb_window

Parametrised framebuffer window renderer for the RGB LCD path. From the timing generator's pixel coordinates it generates framebuffer read addresses, applies runtime integer upscaling (1x/2x/4x), and composites the picture, an optional border and the background into a registered `pixel_data`. It sits between the LCD timing driver and the read port of the dual-clock framebuffer RAM. Fill of that RAM happens in the `sys_clk` domain and is outside this block.

## Interface
- `X_START`, default 11'd1: screen x of the window's left edge, border excluded.
- `Y_START`, default 11'd1: screen y of the window's top edge.
- `PIC_W`, default 400: source picture width in pixels.
- `PIC_H`, default 300: source picture height in pixels.
- `COLOR_W`, default 24: pixel width.
- `ADDR_W`, default 17: framebuffer address width. Must satisfy PIC_W*PIC_H ≤ 2^ADDR_W.
- `RD_LAT`, default 1: framebuffer read latency in cycles (1..3).
- `BORDER_W`, default 2: border thickness in screen pixels. 0 disables the border.
- `BG_COLOR`, default 24'hE0FFFF: background colour.
- `BORDER_COLOR`, default 24'hFF0000: border colour.

Ports:
- `lcd_pclk`, in, 1: pixel clock. All logic is on this clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `pixel_xpos`, in, 11: current pixel x. Advances by 1 per cycle in the active area.
- `pixel_ypos`, in, 11: current pixel y.
- `scale_sel`, in, 2: 00 = 1x, 01 = 2x, 10 = 4x, 11 = 1x.
- `win_en`, in, 1: window display enable.
- `fb_rd_en`, out, 1: framebuffer read enable.
- `fb_rd_addr`, out, ADDR_W: framebuffer read address.
- `fb_rd_data`, in, COLOR_W: read data, valid RD_LAT cycles after the address.
- `pixel_data`, out, COLOR_W: composited pixel.
- `frame_done`, out, 1: one-cycle pulse when the last picture address is issued.

## Operation
- **Frame-start latch.** At frame start (pixel_xpos==0 and pixel_ypos==0), latch `scale_sel` into S (1, 2 or 4) and `win_en` into `en_q`. Both are held for the whole frame, so mid-frame changes have no effect until the next frame.
- **Window extents.** win_x = [X_START, X_START+PIC_W*S). win_y = [Y_START, Y_START+PIC_H*S). Border region = the window grown by BORDER_W on every side, minus the window itself. Border pixels with coordinates below 0 are clipped.
- **Classification.** Each coordinate is classified as PIC (inside the window and en_q), BORDER (border region and en_q), or BG (everything else, and all pixels when en_q=0).
- **Address generation.** Incremental; no multiplier. The row_base counter increments by PIC_W; S ≤ 4.
  - Registers: `row_base` (ADDR_W), `sub_y` (2b), `col` (ADDR_W), `sub_x` (2b).
  - First window line (pixel_ypos==Y_START, first cycle of the line): row_base=0, sub_y=0.
  - New line detection: pixel_ypos differs from its value in the previous cycle.
  - On a new line inside win_y other than the first: if sub_y==S-1, set sub_y=0 and row_base+=PIC_W; otherwise sub_y++.
  - At pixel_xpos==X_START inside win_y: col=0, sub_x=0.
  - On each further PIC cycle: if sub_x==S-1, set sub_x=0 and col++; otherwise sub_x++.
  - Address = row_base + col. This is the combinational next value, registered into `fb_rd_addr`.
- **Read enable.** `fb_rd_en` is 1 exactly on cycles whose registered address belongs to a PIC pixel. In all other cycles `fb_rd_addr` holds its last value.
- **frame_done.** Asserted with the address (PIC_H-1)*PIC_W + PIC_W-1. For S>1 that address is issued several times; `frame_done` pulses only on the last issue, i.e. sub_x==S-1 and sub_y==S-1.
- **Address reset.** Address state resets to 0 when pixel_ypos ≥ Y_START+PIC_H*S, or at frame start.
- **Compositing.** The class code is delayed along the read pipeline so it stays aligned with the data.
  - PIC: `pixel_data` = fb_rd_data.
  - BORDER: `pixel_data` = BORDER_COLOR.
  - BG: `pixel_data` = BG_COLOR.

## Timing
- **Reset values.** pixel_data=BG_COLOR, fb_rd_en=0, fb_rd_addr=0, frame_done=0, S=1, en_q=0, all counters 0. Reset acts immediately, including mid-frame. The first frame after reset is BG until the next frame start latches `win_en`.
- **Pipeline.** Coordinates at cycle t → fb_rd_addr/fb_rd_en/frame_done registered at t+1 → fb_rd_data valid at t+1+RD_LAT → pixel_data registered at t+2+RD_LAT. The total latency of L = RD_LAT+2 applies uniformly to PIC, BORDER and BG pixels. The timing driver compensates for L.
- **Back-to-back reads.** Addresses are issued back to back, one per cycle, with no stalls. The framebuffer must accept one read per cycle.
- **Window overflow.** If the window extends past the panel, addressing simply never reaches the end. `frame_done` is then not asserted; this is allowed.
- **Out-of-range scale.** For S where PIC_H*S overflows 11 bits, behaviour is undefined. Integration checks must prevent this configuration.

## Test plan
- **1x, RD_LAT=1, PIC_W=4, PIC_H=3, X/Y_START=2, BORDER_W=1.** Sweep a 10x8 raster with fb_rd_data=address. pixel_data at screen (2..5, 2..4) = 0..11 row-major, 3 cycles after each coordinate. The ring x∈[1,6], y∈[1,5] = BORDER_COLOR; elsewhere BG_COLOR. `frame_done` pulses once at address 11.
- **2x with the same parameters.** Each source pixel covers a 2x2 block. Screen (2,2),(3,2),(2,3),(3,3) = 0; (4,2) = 1; (2,4) = 4. `frame_done` pulses once, at screen (9,7).
- **Frame-start latching.** Change `scale_sel` from 00 to 10 mid-frame: the current frame stays 1x and the next frame is 4x. Deassert `win_en` mid-frame: the next frame is all BG and fb_rd_en stays 0.
- **RD_LAT=3.** Output latency is 5 cycles for PIC, BORDER and BG pixels alike, and no colour edges are misaligned at window boundaries.
- **Reset mid-frame.** Assert rst_n low while inside the window: outputs return to reset values immediately. After release, the next frame is BG; the one after renders correctly starting from address 0.
- **Blanking gaps.** Hold pixel_xpos constant for 20 cycles between lines: no extra row_base increments and no spurious fb_rd_en.
